// File: rtl/vga_fb_arbiter_pkg.sv
// Shared constants and types for the VGA frame-buffer arbiter slice.
package vga_fb_pkg;

  localparam int H_RES    = 640;
  localparam int V_RES    = 480;
  localparam int FB_DEPTH = H_RES * V_RES;
  localparam int ADDR_W   = 19;
  localparam int DATA_W   = 12;

  typedef enum logic {
    CLR_IDLE,
    CLR_RUN
  } clr_state_e;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Single-port frame-buffer RAM bus; the arbiter drives it, the RAM answers.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = vga_fb_pkg::ADDR_W,
  parameter int DATA_W = vga_fb_pkg::DATA_W
);
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output addr, output we, output wdata, input rdata);
  modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/vga_fb_arbiter_fb_clear_engine.sv
// Full-screen clear engine: latches a fill colour and walks every frame-buffer
// address once, holding its position whenever the display owns the RAM.
//
// state    | meaning
// CLR_IDLE | no clear pending; clr_req starts one
// CLR_RUN  | busy; one word written per non-paused cycle
module fb_clear_engine #(
  parameter int AW    = vga_fb_pkg::ADDR_W,
  parameter int DW    = vga_fb_pkg::DATA_W,
  parameter int DEPTH = vga_fb_pkg::FB_DEPTH
) (
  input  logic          pclk,
  input  logic          reset,
  input  logic          clr_req,
  input  logic [DW-1:0] clr_color,
  input  logic          pause,
  output logic          busy,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data
);
  import vga_fb_pkg::*;

  clr_state_e    state, state_nx;
  logic [AW-1:0] cnt;
  logic [DW-1:0] color;
  logic          last_word;

  assign last_word = (cnt == AW'(DEPTH - 1));

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) state <= CLR_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      CLR_IDLE: if (clr_req) state_nx = CLR_RUN;
      CLR_RUN:  if (!pause && last_word) state_nx = CLR_IDLE;
      default:  state_nx = CLR_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      color <= '0;
    end else if (state == CLR_IDLE) begin
      if (clr_req) begin
        cnt   <= '0;
        color <= clr_color;
      end
    end else if (!pause && !last_word) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign busy = (state == CLR_RUN);
  assign addr = cnt;
  assign data = color;
endmodule

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: scan-out reads own the RAM in active video; blanking
// cycles go to the clear engine, then the pixel writer. Display outputs lag 2 cycles.
module vga_fb_arbiter #(
  parameter int H_RES  = vga_fb_pkg::H_RES,
  parameter int V_RES  = vga_fb_pkg::V_RES,
  parameter int ADDR_W = vga_fb_pkg::ADDR_W,
  parameter int DATA_W = vga_fb_pkg::DATA_W
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic [9:0]        h_addr,
  input  logic [9:0]        v_addr,
  input  logic              valid,
  input  logic              hsync,
  input  logic              vsync,
  output logic [DATA_W-1:0] vga_data,
  output logic              valid_o,
  output logic              hsync_o,
  output logic              vsync_o,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              clr_req,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy,
  vga_fb_arbiter_if.master  ram
);
  localparam int FB_DEPTH = H_RES * V_RES;

  logic [ADDR_W-1:0] disp_addr;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_data;
  logic              we_sel;
  logic              valid_d1, valid_d2, hsync_d1, hsync_d2, vsync_d1, vsync_d2;

  fb_clear_engine #(
    .AW    (ADDR_W),
    .DW    (DATA_W),
    .DEPTH (FB_DEPTH)
  ) u_clear (
    .pclk      (pclk),
    .reset     (reset),
    .clr_req   (clr_req),
    .clr_color (clr_color),
    .pause     (valid),
    .busy      (clr_busy),
    .addr      (clr_addr),
    .data      (clr_data)
  );

  assign disp_addr = ADDR_W'(v_addr) * ADDR_W'(H_RES) + ADDR_W'(h_addr);

  always_comb begin
    ram.addr  = '0;
    ram.wdata = '0;
    we_sel    = 1'b0;
    wr_gnt    = 1'b0;
    if (valid) begin
      ram.addr = disp_addr;
    end else if (clr_busy) begin
      ram.addr  = clr_addr;
      ram.wdata = clr_data;
      we_sel    = 1'b1;
    end else if (wr_req) begin
      ram.addr  = wr_addr;
      ram.wdata = wr_data;
      wr_gnt    = 1'b1;
      // Out-of-range writes are acknowledged but never reach the RAM.
      we_sel    = (wr_addr < ADDR_W'(FB_DEPTH));
    end
    ram.we = we_sel & ~reset;
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      valid_d1 <= 1'b0;
      valid_d2 <= 1'b0;
      hsync_d1 <= 1'b0;
      hsync_d2 <= 1'b0;
      vsync_d1 <= 1'b0;
      vsync_d2 <= 1'b0;
      vga_data <= '0;
    end else begin
      valid_d1 <= valid;
      valid_d2 <= valid_d1;
      hsync_d1 <= hsync;
      hsync_d2 <= hsync_d1;
      vsync_d1 <= vsync;
      vsync_d2 <= vsync_d1;
      vga_data <= valid_d1 ? ram.rdata : '0;
    end
  end

  assign valid_o = valid_d2;
  assign hsync_o = hsync_d2;
  assign vsync_o = vsync_d2;
endmodule
